// File: rtl/mips_core_pkg.sv
// Shared MIPS core definitions: boot/exception vectors and the
// fetch-stage state encoding.
package mips_core_pkg;

  localparam logic [31:0] RESET_PC_DEF = 32'hBFC0_0000;
  localparam logic [31:0] EXC_VECTOR   = 32'hBFC0_0380;

  typedef enum logic [1:0] {
    REQ,
    WAIT,
    HOLD
  } fetch_state_t;

endpackage

// File: rtl/if_fetch_if.sv
// SRAM-like instruction bus, single outstanding request.
// master = fetch stage (drives req/addr), slave = memory side.
interface if_fetch_if;

  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;

  modport master (
    output inst_req,
    output inst_addr,
    input  inst_addr_ok,
    input  inst_data_ok,
    input  inst_rdata
  );

  modport slave (
    input  inst_req,
    input  inst_addr,
    output inst_addr_ok,
    output inst_data_ok,
    output inst_rdata
  );

endinterface

// File: rtl/if_inst_buf.sv
// One-entry IF->ID buffer: valid/PC/instr/AdEL.
// Ports: clk, rst, load_i/clear_i/pop_i controls, entry data in, entry out.
module if_inst_buf (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_i,
  input  logic        clear_i,
  input  logic        pop_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] instr_i,
  input  logic        adel_i,
  output logic        valid_o,
  output logic [31:0] pc_o,
  output logic [31:0] instr_o,
  output logic        adel_o
);

  logic        valid_q;
  logic [31:0] pc_q;
  logic [31:0] instr_q;
  logic        adel_q;

  // Clear/pop only drop valid; stale data is never observed
  // because consumers qualify with valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      pc_q    <= 32'h0;
      instr_q <= 32'h0;
      adel_q  <= 1'b0;
    end else if (clear_i || pop_i) begin
      valid_q <= 1'b0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      pc_q    <= pc_i;
      instr_q <= instr_i;
      adel_q  <= adel_i;
    end
  end

  assign valid_o = valid_q;
  assign pc_o    = pc_q;
  assign instr_o = instr_q;
  assign adel_o  = adel_q;

endmodule

// File: rtl/if_fetch.sv
// Instruction fetch stage: PC register, single-outstanding bus FSM,
// flush/discard handling, one-entry buffer towards ID.
// Ports: clk, rst, NPC/PCWr/IF_Flush in, PC out, ibus (master),
// IF_valid/IF_PC/IF_Instr/IF_AdEL to ID.
module if_fetch
  import mips_core_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] NPC,
  input  logic        PCWr,
  input  logic        IF_Flush,
  output logic [31:0] PC,
  if_fetch_if.master  ibus,
  output logic        IF_valid,
  output logic [31:0] IF_PC,
  output logic [31:0] IF_Instr,
  output logic        IF_AdEL
);

  fetch_state_t state_q;
  logic [31:0]  pc_q;
  logic         discard_q;

  logic in_req;
  logic in_wait;
  logic in_hold;
  logic pc_mis;
  logic req_acc;
  logic rsp;

  logic        buf_load;
  logic        buf_pop;
  logic        adel_load;
  logic        data_load;
  logic [31:0] buf_instr;

  assign in_req  = (state_q == REQ);
  assign in_wait = (state_q == WAIT);
  assign in_hold = (state_q == HOLD);
  assign pc_mis  = (pc_q[1:0] != 2'b00);

  assign ibus.inst_req  = in_req && !pc_mis &&
                          !IF_valid && !rst;
  assign ibus.inst_addr = pc_q;

  assign req_acc = ibus.inst_req && ibus.inst_addr_ok;
  assign rsp     = in_wait && ibus.inst_data_ok;

  assign adel_load = in_req && pc_mis;
  assign data_load = rsp && !discard_q;
  assign buf_load  = !IF_Flush && (adel_load || data_load);
  assign buf_pop   = in_hold && IF_valid && PCWr;
  assign buf_instr = adel_load ? 32'h0 : ibus.inst_rdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= REQ;
      pc_q      <= RESET_PC;
      discard_q <= 1'b0;
    end else if (IF_Flush) begin
      pc_q <= NPC;
      if (rsp) begin
        // The outstanding response lands on the flush cycle
        // itself: nothing is left in flight to discard.
        state_q   <= REQ;
        discard_q <= 1'b0;
      end else if (in_wait || req_acc) begin
        state_q   <= WAIT;
        discard_q <= 1'b1;
      end else begin
        state_q <= REQ;
      end
    end else begin
      unique case (state_q)
        REQ: begin
          if (pc_mis)
            state_q <= HOLD;
          else if (req_acc)
            state_q <= WAIT;
        end
        WAIT: begin
          if (ibus.inst_data_ok) begin
            if (discard_q) begin
              discard_q <= 1'b0;
              state_q   <= REQ;
            end else begin
              state_q <= HOLD;
            end
          end
        end
        HOLD: begin
          if (buf_pop) begin
            pc_q    <= NPC;
            state_q <= REQ;
          end
        end
        default: state_q <= REQ;
      endcase
    end
  end

  if_inst_buf u_buf (
    .clk     (clk),
    .rst     (rst),
    .load_i  (buf_load),
    .clear_i (IF_Flush),
    .pop_i   (buf_pop),
    .pc_i    (pc_q),
    .instr_i (buf_instr),
    .adel_i  (adel_load),
    .valid_o (IF_valid),
    .pc_o    (IF_PC),
    .instr_o (IF_Instr),
    .adel_o  (IF_AdEL)
  );

  assign PC = pc_q;

  // A response is only legal while one is outstanding.
  ap_no_stray_rsp: assert property (
    @(posedge clk) disable iff (rst)
    ibus.inst_data_ok |-> (in_wait || discard_q)
  );

endmodule

// File: tb/tb_if_fetch.sv
// Self-checking bench for if_fetch: transaction-level model plus
// directed scenarios with literal expectations.
module tb_if_fetch;
  import mips_core_pkg::*;

  localparam logic [31:0] BOOT = 32'hBFC0_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] NPC = 32'h0;
  logic        PCWr = 1'b0;
  logic        IF_Flush = 1'b0;
  logic [31:0] PC;
  logic        IF_valid;
  logic [31:0] IF_PC;
  logic [31:0] IF_Instr;
  logic        IF_AdEL;

  if_fetch_if ibus();

  if_fetch #(.RESET_PC(BOOT)) dut (
    .clk      (clk),
    .rst      (rst),
    .NPC      (NPC),
    .PCWr     (PCWr),
    .IF_Flush (IF_Flush),
    .PC       (PC),
    .ibus     (ibus),
    .IF_valid (IF_valid),
    .IF_PC    (IF_PC),
    .IF_Instr (IF_Instr),
    .IF_AdEL  (IF_AdEL)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t",
               nm, act, exp, $time);
    end
  endtask

  // Model: count outstanding/stale responses, track PC and buffer.
  logic [31:0] m_pc;
  logic [31:0] m_bpc;
  logic [31:0] m_bi;
  logic        m_out;
  logic        m_stale;
  logic        m_bv;
  logic        m_badel;
  bit          m_live = 0;

  function automatic logic m_req();
    return !rst && !m_out && !m_bv && (m_pc[1:0] == 2'b00);
  endfunction

  always @(posedge clk) begin
    logic req;
    if (rst) begin
      m_pc = BOOT; m_out = 0; m_stale = 0;
      m_bv = 0; m_bpc = 0; m_bi = 0; m_badel = 0;
      m_live = 1;
    end else if (m_live) begin
      req = m_req();
      if (IF_Flush) begin
        m_pc = NPC;
        m_bv = 0;
        if (m_out && ibus.inst_data_ok) begin
          m_out = 0; m_stale = 0;
        end else if (m_out || (req && ibus.inst_addr_ok)) begin
          m_out = 1; m_stale = 1;
        end
      end else if (m_out && ibus.inst_data_ok) begin
        m_out = 0;
        if (m_stale) m_stale = 0;
        else begin
          m_bv = 1; m_bpc = m_pc;
          m_bi = ibus.inst_rdata; m_badel = 0;
        end
      end else if (!m_out && !m_bv && m_pc[1:0] != 2'b00) begin
        m_bv = 1; m_bpc = m_pc; m_bi = 0; m_badel = 1;
      end else if (req && ibus.inst_addr_ok) begin
        m_out = 1;
      end else if (m_bv && PCWr) begin
        m_bv = 0;
        m_pc = NPC;
      end
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      chk("PC", PC, m_pc);
      chk("inst_req", 32'(ibus.inst_req), 32'(m_req()));
      if (m_req()) chk("inst_addr", ibus.inst_addr, m_pc);
      chk("IF_valid", 32'(IF_valid), 32'(m_bv));
      if (m_bv) begin
        chk("IF_PC", IF_PC, m_bpc);
        chk("IF_Instr", IF_Instr, m_bi);
        chk("IF_AdEL", 32'(IF_AdEL), 32'(m_badel));
      end
    end
  end

  // Zero-wait memory responder, active when auto_bus is set.
  bit          auto_bus = 1;
  bit          pend = 0;
  logic [31:0] paddr = 32'h0;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a == BOOT) ? 32'h2408_0001 : {a[15:0], 16'hC0DE};
  endfunction

  initial begin
    ibus.inst_addr_ok = 1'b0;
    ibus.inst_data_ok = 1'b0;
    ibus.inst_rdata   = 32'h0;
    forever begin
      @(negedge clk);
      #2;
      if (auto_bus) begin
        ibus.inst_data_ok = pend;
        ibus.inst_rdata   = pend ? mem(paddr) : 32'h0;
        pend = 0;
        ibus.inst_addr_ok = ibus.inst_req;
        if (ibus.inst_req) begin
          pend  = 1;
          paddr = ibus.inst_addr;
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic run_auto(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      PCWr = 1'b1;
      NPC  = m_pc + 32'd4;
    end
    PCWr = 1'b0;
  endtask

  initial begin
    tick(); tick();
    chk("rst IF_valid", 32'(IF_valid), 32'h0);
    chk("rst IF_PC", IF_PC, 32'h0);
    chk("rst IF_Instr", IF_Instr, 32'h0);
    chk("rst IF_AdEL", 32'(IF_AdEL), 32'h0);
    chk("rst PC", PC, BOOT);
    chk("rst inst_req", 32'(ibus.inst_req), 32'h0);

    rst = 1'b0;
    #1;
    chk("c1 inst_req", 32'(ibus.inst_req), 32'h1);
    chk("c1 inst_addr", ibus.inst_addr, BOOT);
    tick(); tick();
    chk("c3 IF_valid", 32'(IF_valid), 32'h1);
    chk("c3 IF_PC", IF_PC, BOOT);
    chk("c3 IF_Instr", IF_Instr, 32'h2408_0001);

    repeat (4) tick();
    chk("stall IF_valid", 32'(IF_valid), 32'h1);
    chk("stall IF_Instr", IF_Instr, 32'h2408_0001);
    chk("stall inst_req", 32'(ibus.inst_req), 32'h0);
    chk("stall PC", PC, BOOT);
    PCWr = 1'b1;
    NPC  = 32'hBFC0_0004;
    tick();
    PCWr = 1'b0;
    chk("next inst_req", 32'(ibus.inst_req), 32'h1);
    chk("next inst_addr", ibus.inst_addr, 32'hBFC0_0004);

    run_auto(9);
    for (int i = 0; i < 5 && !IF_valid; i++) tick();
    chk("reach HOLD", 32'(IF_valid), 32'h1);

    // Manual bus from here on.
    auto_bus = 0;
    pend = 0;
    ibus.inst_addr_ok = 1'b0;
    ibus.inst_data_ok = 1'b0;
    PCWr = 1'b1;
    NPC  = 32'hBFC0_0020;
    tick();
    PCWr = 1'b0;
    ibus.inst_addr_ok = 1'b1;
    tick();
    ibus.inst_addr_ok = 1'b0;
    IF_Flush = 1'b1;
    NPC = EXC_VECTOR;
    tick();
    IF_Flush = 1'b0;
    ibus.inst_data_ok = 1'b1;
    ibus.inst_rdata   = 32'hDEAD_BEEF;
    tick();
    ibus.inst_data_ok = 1'b0;
    chk("flw IF_valid", 32'(IF_valid), 32'h0);
    chk("flw inst_req", 32'(ibus.inst_req), 32'h1);
    chk("flw inst_addr", ibus.inst_addr, 32'hBFC0_0380);
    ibus.inst_addr_ok = 1'b1;
    tick();
    ibus.inst_addr_ok = 1'b0;
    ibus.inst_data_ok = 1'b1;
    ibus.inst_rdata   = 32'h1111_1111;
    tick();
    ibus.inst_data_ok = 1'b0;
    chk("flw2 IF_valid", 32'(IF_valid), 32'h1);
    chk("flw2 IF_Instr", IF_Instr, 32'h1111_1111);
    chk("flw2 IF_PC", IF_PC, 32'hBFC0_0380);
    PCWr = 1'b1;
    NPC  = 32'hBFC0_0400;
    tick();
    PCWr = 1'b0;

    ibus.inst_addr_ok = 1'b1;
    IF_Flush = 1'b1;
    NPC = 32'hBFC0_0500;
    tick();
    ibus.inst_addr_ok = 1'b0;
    IF_Flush = 1'b0;
    ibus.inst_data_ok = 1'b1;
    ibus.inst_rdata   = 32'hBAD0_BAD0;
    tick();
    ibus.inst_data_ok = 1'b0;
    chk("flr IF_valid", 32'(IF_valid), 32'h0);
    chk("flr inst_req", 32'(ibus.inst_req), 32'h1);
    chk("flr inst_addr", ibus.inst_addr, 32'hBFC0_0500);
    ibus.inst_addr_ok = 1'b1;
    tick();
    ibus.inst_addr_ok = 1'b0;
    ibus.inst_data_ok = 1'b1;
    ibus.inst_rdata   = 32'h2222_0000;
    tick();
    ibus.inst_data_ok = 1'b0;
    chk("flr2 IF_valid", 32'(IF_valid), 32'h1);
    chk("flr2 IF_Instr", IF_Instr, 32'h2222_0000);
    chk("flr2 IF_PC", IF_PC, 32'hBFC0_0500);

    PCWr = 1'b1;
    NPC  = 32'hBFC0_0102;
    tick();
    PCWr = 1'b0;
    chk("mis inst_req", 32'(ibus.inst_req), 32'h0);
    tick();
    chk("mis IF_valid", 32'(IF_valid), 32'h1);
    chk("mis IF_AdEL", 32'(IF_AdEL), 32'h1);
    chk("mis IF_PC", IF_PC, 32'hBFC0_0102);
    chk("mis IF_Instr", IF_Instr, 32'h0);
    chk("mis inst_req2", 32'(ibus.inst_req), 32'h0);

    PCWr = 1'b1;
    NPC  = 32'hBFC0_0010;
    tick();
    PCWr = 1'b0;
    ibus.inst_addr_ok = 1'b1;
    tick();
    ibus.inst_addr_ok = 1'b0;
    rst = 1'b1;
    #1;
    chk("rstw PC", PC, BOOT);
    chk("rstw inst_req", 32'(ibus.inst_req), 32'h0);
    chk("rstw IF_valid", 32'(IF_valid), 32'h0);
    tick();
    ibus.inst_data_ok = 1'b1;
    ibus.inst_rdata   = 32'h3333_3333;
    tick();
    ibus.inst_data_ok = 1'b0;
    rst = 1'b0;
    #1;
    chk("rstw2 IF_valid", 32'(IF_valid), 32'h0);
    chk("rstw2 inst_req", 32'(ibus.inst_req), 32'h1);
    chk("rstw2 inst_addr", ibus.inst_addr, BOOT);

    auto_bus = 1;
    pend = 0;
    run_auto(10);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
